csr_trap_seq: RTL and testbench

Sequencer and arbiter for the machine-mode CSR file (`CSRs`). It owns the file's single read/write port and shares it between two requesters: the pipeline's Zicsr instructions (CSRRW/CSRRS/CSRRC read-modify-write) and the trap unit (trap entry and `mret`). For traps it performs the multi-cycle update of mepc, mcause, mtval and mstatus, then reads mtvec or mepc to produce a PC redirect for fetch.

---
 rtl/csr_pkg.sv | 33 +++
 rtl/csr_rmw.sv | 32 +++
 rtl/csr_trap_seq.sv | 167 ++++++++++++++++
 tb/tb_csr_trap_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR sequencer: CSR addresses, mstatus bit
// positions, the Zicsr op encoding and the sequencer state encoding.
package csr_pkg;

   localparam logic [11:0] CSR_MSTATUS  = 12'h300;
   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH = 12'h340;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] CSR_MTVAL    = 12'h343;

   localparam int MSTATUS_MIE  = 3;
   localparam int MSTATUS_MPIE = 7;

   typedef enum logic [1:0] {
      CSR_RW = 2'd0,
      CSR_RS = 2'd1,
      CSR_RC = 2'd2
   } csr_op_t;

   typedef enum logic [3:0] {
      S_IDLE,
      S_INSN,
      S_T_EPC,
      S_T_CAUSE,
      S_T_TVAL,
      S_T_STATUS,
      S_T_VEC,
      S_M_STATUS,
      S_M_EPC
   } seq_state_t;

endpackage

// File: rtl/csr_rmw.sv
// Zicsr next-value unit: combinational, zero latency, no flow control.
// Set/clear with a zero operand suppresses the write so read-only side effects never fire.
module csr_rmw
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] old_val,
   input  logic [XLEN-1:0] src,
   output logic [XLEN-1:0] new_val,
   output logic            wr_en
);

   always_comb begin
      new_val = src;
      wr_en   = 1'b1;
      case (csr_op_t'(op))
         CSR_RS: begin
            new_val = old_val | src;
            wr_en   = |src;
         end
         CSR_RC: begin
            new_val = old_val & ~src;
            wr_en   = |src;
         end
         // encoding 3 behaves as a plain write
         default: ;
      endcase
   end

endmodule

// File: rtl/csr_trap_seq.sv
// Arbitrates the CSR file port between Zicsr insns and trap/mret; insn 2 cycles, trap 6, mret 3.
// Requests are held off (ready low) whenever the sequencer is not idle; trap beats mret beats insn.
module csr_trap_seq
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rstl,
   input  logic            insn_valid,
   output logic            insn_ready,
   input  logic [1:0]      insn_op,
   input  logic [11:0]     insn_addr,
   input  logic [XLEN-1:0] insn_src,
   output logic            insn_done,
   output logic [XLEN-1:0] insn_rdata,
   input  logic            trap_valid,
   input  logic            mret_valid,
   output logic            trap_ready,
   input  logic [XLEN-1:0] trap_cause,
   input  logic [XLEN-1:0] trap_pc,
   input  logic [XLEN-1:0] trap_tval,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            csr_w,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_din,
   input  logic [XLEN-1:0] csr_dout
);

   seq_state_t      state_q, state_d;
   logic [1:0]      op_q;
   logic [11:0]     addr_q;
   logic [XLEN-1:0] src_q;
   logic [XLEN-1:0] cause_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] tval_q;

   logic [XLEN-1:0] rmw_new;
   logic            rmw_wr;
   logic [XLEN-1:0] status_trap;
   logic [XLEN-1:0] status_mret;
   logic [XLEN-1:0] vec_base;
   logic [XLEN-1:0] vec_off;
   logic [XLEN-1:0] vec_pc;

   assign trap_ready = (state_q == S_IDLE) && (trap_valid || mret_valid);
   assign insn_ready = (state_q == S_IDLE) && insn_valid && !trap_valid && !mret_valid;

   always_ff @(posedge clk or negedge rstl) begin
      if (!rstl) begin
         state_q <= S_IDLE;
         op_q    <= '0;
         addr_q  <= '0;
         src_q   <= '0;
         cause_q <= '0;
         pc_q    <= '0;
         tval_q  <= '0;
      end else begin
         state_q <= state_d;
         if (insn_ready) begin
            op_q   <= insn_op;
            addr_q <= insn_addr;
            src_q  <= insn_src;
         end
         if (trap_ready && trap_valid) begin
            cause_q <= trap_cause;
            pc_q    <= trap_pc;
            tval_q  <= trap_tval;
         end
      end
   end

   csr_rmw #(
      .XLEN(XLEN)
   ) u_rmw (
      .op      (op_q),
      .old_val (csr_dout),
      .src     (src_q),
      .new_val (rmw_new),
      .wr_en   (rmw_wr)
   );

   always_comb begin
      status_trap               = csr_dout;
      status_trap[MSTATUS_MPIE] = csr_dout[MSTATUS_MIE];
      status_trap[MSTATUS_MIE]  = 1'b0;
      status_mret               = csr_dout;
      status_mret[MSTATUS_MIE]  = csr_dout[MSTATUS_MPIE];
      status_mret[MSTATUS_MPIE] = 1'b1;
   end

   // Vectored target: 4*cause[XLEN-2:0], wrapping modulo 2^XLEN.
   assign vec_base = csr_dout & ~XLEN'(3);
   assign vec_off  = {1'b0, cause_q[XLEN-2:0]} << 2;
   assign vec_pc   = (csr_dout[1:0] == 2'b01 && cause_q[XLEN-1]) ? vec_base + vec_off : vec_base;

   always_comb begin
      state_d        = state_q;
      csr_w          = 1'b0;
      csr_addr       = '0;
      csr_din        = '0;
      insn_done      = 1'b0;
      insn_rdata     = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      case (state_q)
         S_IDLE: begin
            if (trap_valid)      state_d = S_T_EPC;
            else if (mret_valid) state_d = S_M_STATUS;
            else if (insn_valid) state_d = S_INSN;
         end
         S_INSN: begin
            csr_addr   = addr_q;
            csr_din    = rmw_new;
            csr_w      = rmw_wr;
            insn_done  = 1'b1;
            insn_rdata = csr_dout;
            state_d    = S_IDLE;
         end
         S_T_EPC: begin
            csr_addr = CSR_MEPC;
            csr_din  = pc_q & ~XLEN'(1);
            csr_w    = 1'b1;
            state_d  = S_T_CAUSE;
         end
         S_T_CAUSE: begin
            csr_addr = CSR_MCAUSE;
            csr_din  = cause_q;
            csr_w    = 1'b1;
            state_d  = S_T_TVAL;
         end
         S_T_TVAL: begin
            csr_addr = CSR_MTVAL;
            csr_din  = tval_q;
            csr_w    = 1'b1;
            state_d  = S_T_STATUS;
         end
         S_T_STATUS: begin
            csr_addr = CSR_MSTATUS;
            csr_din  = status_trap;
            csr_w    = 1'b1;
            state_d  = S_T_VEC;
         end
         S_T_VEC: begin
            csr_addr       = CSR_MTVEC;
            redirect_valid = 1'b1;
            redirect_pc    = vec_pc;
            state_d        = S_IDLE;
         end
         S_M_STATUS: begin
            csr_addr = CSR_MSTATUS;
            csr_din  = status_mret;
            csr_w    = 1'b1;
            state_d  = S_M_EPC;
         end
         S_M_EPC: begin
            csr_addr       = CSR_MEPC;
            redirect_valid = 1'b1;
            redirect_pc    = csr_dout & ~XLEN'(1);
            state_d        = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_csr_trap_seq.sv
// Self-checking bench for csr_trap_seq with a behavioural CSR file attached to its port.
// Directed vector table for Zicsr ops plus hand-written trap, mret, arbitration and reset sequences.
module tb_csr_trap_seq;
   import csr_pkg::*;

   logic        clk;
   logic        rstl;
   logic        insn_valid;
   logic        insn_ready;
   logic [1:0]  insn_op;
   logic [11:0] insn_addr;
   logic [31:0] insn_src;
   logic        insn_done;
   logic [31:0] insn_rdata;
   logic        trap_valid;
   logic        mret_valid;
   logic        trap_ready;
   logic [31:0] trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        csr_w;
   logic [11:0] csr_addr;
   logic [31:0] csr_din;
   logic [31:0] csr_dout;

   int n_tests = 0;
   int n_fail  = 0;

   csr_trap_seq #(.XLEN(32)) dut (
      .clk            (clk),
      .rstl           (rstl),
      .insn_valid     (insn_valid),
      .insn_ready     (insn_ready),
      .insn_op        (insn_op),
      .insn_addr      (insn_addr),
      .insn_src       (insn_src),
      .insn_done      (insn_done),
      .insn_rdata     (insn_rdata),
      .trap_valid     (trap_valid),
      .mret_valid     (mret_valid),
      .trap_ready     (trap_ready),
      .trap_cause     (trap_cause),
      .trap_pc        (trap_pc),
      .trap_tval      (trap_tval),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .csr_w          (csr_w),
      .csr_addr       (csr_addr),
      .csr_din        (csr_din),
      .csr_dout       (csr_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural CSR file, reset independently so it survives a sequencer reset.
   logic        mdl_rst_n;
   logic [31:0] m_status, m_tvec, m_epc, m_cause, m_tval, m_scratch;

   always_ff @(posedge clk or negedge mdl_rst_n) begin
      if (!mdl_rst_n) begin
         m_status  <= '0;
         m_tvec    <= '0;
         m_epc     <= '0;
         m_cause   <= '0;
         m_tval    <= '0;
         m_scratch <= '0;
      end else if (csr_w) begin
         case (csr_addr)
            CSR_MSTATUS:  m_status  <= csr_din;
            CSR_MTVEC:    m_tvec    <= csr_din;
            CSR_MEPC:     m_epc     <= csr_din;
            CSR_MCAUSE:   m_cause   <= csr_din;
            CSR_MTVAL:    m_tval    <= csr_din;
            CSR_MSCRATCH: m_scratch <= csr_din;
            default: ;
         endcase
      end
   end

   function automatic logic [31:0] mdl_rd(input logic [11:0] a);
      case (a)
         CSR_MSTATUS:  return m_status;
         CSR_MTVEC:    return m_tvec;
         CSR_MEPC:     return m_epc;
         CSR_MCAUSE:   return m_cause;
         CSR_MTVAL:    return m_tval;
         CSR_MSCRATCH: return m_scratch;
         default:      return 32'h0;
      endcase
   endfunction

   always_comb csr_dout = mdl_rd(csr_addr);

   typedef struct {
      logic [1:0]  op;
      logic [11:0] addr;
      logic [31:0] src;
      logic [31:0] rdata;
      logic        w;
      logic [31:0] after;
   } vec_t;

   vec_t vecs [8];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Returns at the falling edge of the cycle in which the request is accepted.
   task automatic wait_rdy(input bit for_trap);
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         if (for_trap ? trap_ready : insn_ready) return;
         tick();
      end
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got no ready within 16 cycles, want ready");
   endtask

   task automatic do_insn(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] src,
                          output logic [31:0] rd, output logic w, output logic dn);
      insn_op    = op;
      insn_addr  = addr;
      insn_src   = src;
      insn_valid = 1'b1;
      wait_rdy(1'b0);
      tick();
      insn_valid = 1'b0;
      insn_addr  = 12'h000;
      insn_src   = 32'hA5A5A5A5;
      @(negedge clk);
      rd = insn_rdata;
      w  = csr_w;
      dn = insn_done;
      tick();
   endtask

   task automatic setup_write(input logic [11:0] a, input logic [31:0] v);
      logic [31:0] rd;
      logic        w, dn;
      do_insn(2'd0, a, v, rd, w, dn);
      check("setup_done_w", {31'd0, dn & w}, 32'd1);
      check("setup_value", mdl_rd(a), v);
   endtask

   task automatic do_trap(input logic [31:0] cause, input logic [31:0] pc, input logic [31:0] tval,
                          input logic [31:0] exp_pc);
      trap_cause = cause;
      trap_pc    = pc;
      trap_tval  = tval;
      trap_valid = 1'b1;
      wait_rdy(1'b1);
      tick();
      trap_valid = 1'b0;
      trap_cause = 32'hFFFFFFFF;
      trap_pc    = 32'hFFFFFFFF;
      trap_tval  = 32'hFFFFFFFF;
      @(negedge clk);
      check("trap_epc_port", {csr_w, csr_addr}, {1'b1, CSR_MEPC});
      check("trap_epc_din", csr_din, pc & ~32'h1);
      tick(); @(negedge clk);
      check("trap_cause_port", {csr_w, csr_addr}, {1'b1, CSR_MCAUSE});
      check("trap_cause_din", csr_din, cause);
      tick(); @(negedge clk);
      check("trap_tval_port", {csr_w, csr_addr}, {1'b1, CSR_MTVAL});
      tick(); @(negedge clk);
      check("trap_status_port", {csr_w, csr_addr}, {1'b1, CSR_MSTATUS});
      tick(); @(negedge clk);
      check("trap_vec_strobe", {redirect_valid, csr_w}, 2'b10);
      check("trap_redirect_pc", redirect_pc, exp_pc);
      tick(); @(negedge clk);
      check("trap_idle_after", {redirect_valid, csr_w, csr_addr}, 14'h0);
      tick();
   endtask

   logic [31:0] rd;
   logic        w, dn;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{2'd0, CSR_MSCRATCH, 32'hDEADBEEF, 32'h00000000, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{2'd1, CSR_MSCRATCH, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF};
      vecs[2] = '{2'd2, CSR_MSCRATCH, 32'h0000FFFF, 32'hDEADBEEF, 1'b1, 32'hDEAD0000};
      vecs[3] = '{2'd1, CSR_MSCRATCH, 32'h000000F0, 32'hDEAD0000, 1'b1, 32'hDEAD00F0};
      vecs[4] = '{2'd3, CSR_MSCRATCH, 32'h12345678, 32'hDEAD00F0, 1'b1, 32'h12345678};
      vecs[5] = '{2'd2, CSR_MSCRATCH, 32'h00000000, 32'h12345678, 1'b0, 32'h12345678};
      vecs[6] = '{2'd0, CSR_MTVEC,    32'h00000100, 32'h00000000, 1'b1, 32'h00000100};
      vecs[7] = '{2'd1, CSR_MSTATUS,  32'h00000008, 32'h00000000, 1'b1, 32'h00000008};

      rstl       = 1'b0;
      mdl_rst_n  = 1'b0;
      insn_valid = 1'b1;
      insn_op    = 2'd0;
      insn_addr  = CSR_MSCRATCH;
      insn_src   = 32'h0;
      trap_valid = 1'b1;
      mret_valid = 1'b0;
      trap_cause = 32'h0;
      trap_pc    = 32'h0;
      trap_tval  = 32'h0;
      #3;
      check("reset_outputs", {insn_done, redirect_valid, csr_w, csr_addr}, 15'h0);
      check("reset_data", insn_rdata | redirect_pc | csr_din, 32'h0);
      check("reset_ready", {trap_ready, insn_ready}, 2'b10);
      trap_valid = 1'b0;
      #1;
      check("reset_insn_ready", {31'd0, insn_ready}, 32'd1);
      insn_valid = 1'b0;
      mdl_rst_n  = 1'b1;
      tick(); tick();
      rstl = 1'b1;
      tick();

      for (int i = 0; i < 8; i++) begin
         do_insn(vecs[i].op, vecs[i].addr, vecs[i].src, rd, w, dn);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].rdata);
         check($sformatf("vec%0d_w_done", i), {30'd0, w, dn}, {30'd0, vecs[i].w, 1'b1});
         check($sformatf("vec%0d_after", i), mdl_rd(vecs[i].addr), vecs[i].after);
      end

      // Direct-mode trap with MIE=1 beforehand.
      do_trap(32'd2, 32'h80, 32'h1234, 32'h100);
      check("direct_mepc", m_epc, 32'h80);
      check("direct_mcause", m_cause, 32'd2);
      check("direct_mtval", m_tval, 32'h1234);
      check("direct_mstatus", m_status, 32'h80);

      // Vectored mode: interrupt offsets, exception does not; odd pc is cleared.
      setup_write(CSR_MTVEC, 32'h101);
      do_trap(32'h80000007, 32'h85, 32'h0, 32'h11C);
      check("vec_mepc_even", m_epc, 32'h84);
      check("vec_mstatus", m_status, 32'h0);
      do_trap(32'd7, 32'h88, 32'h55, 32'h100);
      check("exc_mtval", m_tval, 32'h55);

      // Vectored target wraps past 2^32.
      setup_write(CSR_MTVEC, 32'hFFFFFFF1);
      do_trap(32'h80000007, 32'h0, 32'h0, 32'h0000000C);
      do_trap(32'h80000003, 32'h4, 32'h0, 32'hFFFFFFFC);

      // mret: MIE <- MPIE, MPIE <- 1, redirect to even mepc.
      setup_write(CSR_MEPC, 32'h201);
      setup_write(CSR_MSTATUS, 32'h80);
      mret_valid = 1'b1;
      wait_rdy(1'b1);
      tick();
      mret_valid = 1'b0;
      @(negedge clk);
      check("mret_status_port", {csr_w, csr_addr}, {1'b1, CSR_MSTATUS});
      check("mret_status_din", csr_din, 32'h88);
      tick(); @(negedge clk);
      check("mret_strobe", {redirect_valid, csr_w}, 2'b10);
      check("mret_redirect_pc", redirect_pc, 32'h200);
      tick();
      check("mret_mstatus", m_status, 32'h88);

      // trap + mret + insn together: trap wins, insn waits until N+6.
      trap_cause = 32'd3;
      trap_pc    = 32'h90;
      trap_tval  = 32'h0;
      trap_valid = 1'b1;
      mret_valid = 1'b1;
      insn_op    = 2'd1;
      insn_addr  = CSR_MSCRATCH;
      insn_src   = 32'h0;
      insn_valid = 1'b1;
      wait_rdy(1'b1);
      check("conc_insn_stall_n0", {31'd0, insn_ready}, 32'd0);
      tick();
      trap_valid = 1'b0;
      mret_valid = 1'b0;
      @(negedge clk);
      check("conc_trap_first", {csr_w, csr_addr}, {1'b1, CSR_MEPC});
      for (int k = 2; k <= 5; k++) begin
         tick(); @(negedge clk);
         check($sformatf("conc_insn_stall_n%0d", k), {31'd0, insn_ready}, 32'd0);
      end
      check("conc_redirect_pc", redirect_pc, 32'hFFFFFFF0);
      tick(); @(negedge clk);
      check("conc_insn_ready_n6", {31'd0, insn_ready}, 32'd1);
      tick();
      insn_valid = 1'b0;
      @(negedge clk);
      check("conc_insn_done_w", {30'd0, insn_done, csr_w}, 32'd2);
      check("conc_insn_rdata", insn_rdata, 32'h12345678);
      tick();

      // Reset while in T_CAUSE: mepc write stays, no further writes.
      trap_cause = 32'd5;
      trap_pc    = 32'h3FE;
      trap_tval  = 32'h77;
      trap_valid = 1'b1;
      wait_rdy(1'b1);
      tick();
      trap_valid = 1'b0;
      tick();
      @(negedge clk);
      check("rst_in_cause", {csr_w, csr_addr}, {1'b1, CSR_MCAUSE});
      #1;
      rstl       = 1'b0;
      trap_valid = 1'b1;
      #1;
      check("rst_mid_outputs", {csr_w, redirect_valid, trap_ready}, 3'b001);
      tick();
      check("rst_next_cycle", {csr_w, redirect_valid, trap_ready}, 3'b001);
      check("rst_mepc_kept", m_epc, 32'h3FE);
      check("rst_mcause_untouched", m_cause, 32'd3);
      check("rst_mtval_untouched", m_tval, 32'h0);
      trap_valid = 1'b0;
      rstl       = 1'b1;
      tick();
      do_insn(2'd1, CSR_MSCRATCH, 32'h0, rd, w, dn);
      check("post_rst_rdata", rd, 32'h12345678);
      check("post_rst_done", {30'd0, w, dn}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
